// File: rtl/blit_pkg.sv
// Shared screen geometry, pixel format and blitter state encoding.
package blit_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIX_W    = 5;
  localparam int FB_AW    = 19;

  localparam logic [PIX_W-1:0] TRANSPARENT = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;
endpackage

// File: rtl/blit_addr_gen.sv
// Raster walker over the sprite: row/col counters, ROM address and screen
// coordinates/linear address for the pixel currently being fetched.
module blit_addr_gen
  import blit_pkg::*;
#(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int ROM_AW = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [9:0]        pos_x_i,
  input  logic [9:0]        pos_y_i,
  input  logic [ROM_AW-1:0] frame_base_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic [10:0]       sx_o,
  output logic [10:0]       sy_o,
  output logic [FB_AW-1:0]  fb_addr_o,
  output logic              last_o
);
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [FB_AW-1:0] ROW_STEP = FB_AW'(SCREEN_W);

  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [FB_AW-1:0]  row_base_q;
  logic [9:0]        px_q, py_q;
  logic [ROM_AW-1:0] base_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      px_q       <= '0;
      py_q       <= '0;
      base_q     <= '0;
    end else if (load_i) begin
      col_q      <= '0;
      row_q      <= '0;
      // y*640 as y*512 + y*128
      row_base_q <= (FB_AW'(pos_y_i) << 9) + (FB_AW'(pos_y_i) << 7);
      px_q       <= pos_x_i;
      py_q       <= pos_y_i;
      base_q     <= frame_base_i;
    end else if (adv_i) begin
      if (col_q == CW'(SPR_W - 1)) begin
        col_q      <= '0;
        row_q      <= row_q + RW'(1);
        row_base_q <= row_base_q + ROW_STEP;
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // SPR_W is a power of two, so row*SPR_W + col is a plain concatenation
  assign rom_addr_o = base_q + ROM_AW'({row_q, col_q});
  assign sx_o       = {1'b0, px_q} + 11'(col_q);
  assign sy_o       = {1'b0, py_q} + 11'(row_q);
  assign fb_addr_o  = row_base_q + FB_AW'(px_q) + FB_AW'(col_q);
  assign last_o     = (row_q == RW'(SPR_H - 1)) && (col_q == CW'(SPR_W - 1));
endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one sprite frame from ROM into the frame buffer with
// transparency and right/bottom clipping, one pixel per clock.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int ROM_AW = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [ROM_AW-1:0] frame_base,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [PIX_W-1:0]  fb_data
);
  blit_state_t state_q, state_d;
  logic        load, adv, last;
  logic [10:0] sx, sy;
  logic [FB_AW-1:0] fb_addr_gen;

  logic             valid_q;
  logic [10:0]      sx_q, sy_q;
  logic [FB_AW-1:0] fb_addr_q;

  blit_addr_gen #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .ROM_AW (ROM_AW)
  ) u_addr_gen (
    .Clk          (Clk),
    .Reset        (Reset),
    .load_i       (load),
    .adv_i        (adv),
    .pos_x_i      (pos_x),
    .pos_y_i      (pos_y),
    .frame_base_i (frame_base),
    .rom_addr_o   (rom_addr),
    .sx_o         (sx),
    .sy_o         (sy),
    .fb_addr_o    (fb_addr_gen),
    .last_o       (last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        adv = 1'b1;
        if (last) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write stage: one cycle behind the ROM address, aligned with rom_data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q   <= 1'b0;
      fb_addr_q <= '0;
    end else begin
      valid_q <= (state_q == RUN);
      if (state_q == RUN) fb_addr_q <= fb_addr_gen;
    end
  end

  always_ff @(posedge Clk) begin
    sx_q <= sx;
    sy_q <= sy;
  end

  assign fb_we   = valid_q && (rom_data != TRANSPARENT) &&
                   (sx_q < 11'(SCREEN_W)) && (sy_q < 11'(SCREEN_H));
  assign fb_addr = fb_addr_q;
  assign fb_data = valid_q ? rom_data : '0;
  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized bench for sprite_blitter against a pixel-list reference model.
module tb_sprite_blitter;
  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int ROM_AW = 11;
  localparam int N      = SPR_W * SPR_H;
  localparam int ROM_SZ = 1 << ROM_AW;

  typedef struct packed {
    logic [18:0] addr;
    logic [4:0]  data;
  } wr_t;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              start = 1'b0;
  logic [9:0]        pos_x = '0;
  logic [9:0]        pos_y = '0;
  logic [ROM_AW-1:0] frame_base = '0;
  logic              busy, done, fb_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [4:0]        rom_data = '0;
  logic [18:0]       fb_addr;
  logic [4:0]        fb_data;

  logic [4:0] rom [0:ROM_SZ-1];
  wr_t got_q[$];
  wr_t exp_q[$];
  int tests = 0;
  int fails = 0;

  sprite_blitter #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_AW(ROM_AW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .frame_base (frame_base),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk every sprite pixel, keep the opaque on-screen ones.
  task automatic build_expected(input int px, input int py, input int fbase);
    exp_q.delete();
    for (int r = 0; r < SPR_H; r++)
      for (int c = 0; c < SPR_W; c++) begin
        int a;
        wr_t w;
        a = (fbase + r * SPR_W + c) % ROM_SZ;
        if (rom[a] != 5'd0 && px + c < 640 && py + r < 480) begin
          w.addr = 19'((py + r) * 640 + px + c);
          w.data = rom[a];
          exp_q.push_back(w);
        end
      end
  endtask

  task automatic run_blit(input int px, input int py, input int fbase, input int inj_k);
    int done_k, done_cnt, busy_err, n;
    build_expected(px, py, fbase);
    got_q.delete();
    done_k = -1; done_cnt = 0; busy_err = 0;
    @(negedge Clk);
    pos_x = 10'(px); pos_y = 10'(py); frame_base = ROM_AW'(fbase);
    start = 1'b1;
    for (int k = 1; k <= N + 2; k++) begin
      @(negedge Clk);
      if (busy !== (k <= N + 1)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_k = k;
      end
      if (fb_we === 1'b1) begin
        wr_t w;
        w.addr = fb_addr;
        w.data = fb_data;
        got_q.push_back(w);
      end
      start = (k == inj_k);
      if (k == 1) begin
        pos_x = 10'($urandom);
        pos_y = 10'($urandom);
        frame_base = ROM_AW'($urandom);
      end
    end
    start = 1'b0;
    chk("busy_window", busy_err, 0);
    chk("done_cycle", done_k, N + 2);
    chk("done_pulses", done_cnt, 1);
    chk("wr_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", got_q[i].addr, exp_q[i].addr);
      chk("wr_data", got_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic fill_rom_random();
    for (int i = 0; i < ROM_SZ; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < ROM_SZ; i++) rom[i] = 5'((i % 31) + 1);

    repeat (3) @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_rom_addr", rom_addr, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Full on-screen blit
    run_blit(0, 0, 0, 0);
    chk("full_count", got_q.size(), 1024);
    chk("full_last_addr", (got_q.size() > 0) ? int'(got_q[$].addr) : -1, 19871);

    // Right clip
    run_blit(620, 100, 0, 0);
    chk("rclip_count", got_q.size(), 640);
    chk("rclip_first", (got_q.size() > 0) ? int'(got_q[0].addr) : -1, 64620);

    // Bottom clip
    run_blit(0, 470, 0, 0);
    chk("bclip_count", got_q.size(), 320);
    chk("bclip_last", (got_q.size() > 0) ? int'(got_q[$].addr) : -1, 306591);

    // Transparency
    for (int i = 0; i < ROM_SZ; i++) rom[i] = 5'd0;
    rom[300 + 37] = 5'h1F;
    run_blit(10, 10, 300, 0);
    chk("transp_count", got_q.size(), 1);
    chk("transp_addr", (got_q.size() > 0) ? int'(got_q[0].addr) : -1, 7055);
    chk("transp_data", (got_q.size() > 0) ? int'(got_q[0].data) : -1, 31);

    // Handshake: extra start mid-blit is ignored, back-to-back start accepted
    fill_rom_random();
    run_blit(5, 7, 64, 50);
    run_blit(100, 200, 1000, 0);

    // Reset mid-blit
    @(negedge Clk);
    pos_x = 10'd30; pos_y = 10'd40; frame_base = '0;
    start = 1'b1;
    for (int k = 1; k < 100; k++) begin
      @(negedge Clk);
      start = 1'b0;
    end
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fb_we", fb_we, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_fb_addr", fb_addr, 0);
    Reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (done === 1'b1 || fb_we === 1'b1 || busy === 1'b1) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);
    run_blit(30, 40, 0, 0);

    // Randomized blits, including wrapping ROM addresses and off-screen positions
    for (int t = 0; t < 6; t++) begin
      fill_rom_random();
      run_blit($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, ROM_SZ - 1), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
